// File: rtl/enc8b10b_pkg.sv
// enc8b10b_pkg: shared types and code tables for the 8b/10b encoder.
// Optional K-character support is enabled by defining ENC8B10B_KCHAR_EN.
package enc8b10b_pkg;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_t;

    // 5b/6b abcdei codes indexed by x (EDCBA), chosen by the current running disparity
    localparam logic [0:31][5:0] C_6B_NEG = {
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    localparam logic [0:31][5:0] C_6B_POS = {
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100
    };

    localparam logic [5:0] C_K28_NEG = 6'b001111;
    localparam logic [5:0] C_K28_POS = 6'b110000;

    // x values that force the alternate .7 to avoid a run of five identical bits
    localparam logic [31:0] C_ALT7_NEG = (32'd1 << 17) | (32'd1 << 18) | (32'd1 << 20);
    localparam logic [31:0] C_ALT7_POS = (32'd1 << 11) | (32'd1 << 13) | (32'd1 << 14);

    // x values of the legal K.x.7 characters other than K.28.7
    localparam logic [31:0] C_K7_X = (32'd1 << 23) | (32'd1 << 27) | (32'd1 << 29) | (32'd1 << 30);

    // A 6b sub-block with other than three ones flips the running disparity
    function automatic logic disp6(input logic [5:0] code);
        return ($countones(code) != 3);
    endfunction

endpackage

// File: rtl/enc_8b10b_3b4b.sv
// enc_3b4b: combinational 3b/4b sub-block encoder (fghj) with disparity flip flag.
// Used by enc_8b10b; unaffected by ENC8B10B_KCHAR_EN.
module enc_3b4b
    import enc8b10b_pkg::*;
(
    input  logic [2:0] y,
    input  rd_t        rd6,
    input  logic       alt,
    output logic [3:0] fghj,
    output logic       flip
);

    // Table lookup by y and the disparity left after the 6b sub-block
    always_comb begin
        fghj = 4'b0000;
        flip = 1'b0;
        case (y)
            3'd0: begin fghj = (rd6 == RD_POS) ? 4'b0100 : 4'b1011; flip = 1'b1; end
            3'd1: fghj = 4'b1001;
            3'd2: fghj = 4'b0101;
            3'd3: fghj = (rd6 == RD_POS) ? 4'b0011 : 4'b1100;
            3'd4: begin fghj = (rd6 == RD_POS) ? 4'b0010 : 4'b1101; flip = 1'b1; end
            3'd5: fghj = 4'b1010;
            3'd6: fghj = 4'b0110;
            default: begin
                if (alt)
                    fghj = (rd6 == RD_POS) ? 4'b1000 : 4'b0111;
                else
                    fghj = (rd6 == RD_POS) ? 4'b0001 : 4'b1110;
                flip = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/enc_8b10b.sv
// enc_8b10b: registered 8b/10b encoder with running disparity and valid/ready handshake.
// Define ENC8B10B_KCHAR_EN to encode K.28.x, K.23.7, K.27.7, K.29.7, K.30.7 from in_k.
module enc_8b10b
    import enc8b10b_pkg::*;
#(
    parameter logic RD_INIT = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_code,
    output logic       out_rd,
    output logic       err_k
);

    logic       r_valid;
    logic [9:0] r_code;
    logic       r_err;
    rd_t        r_rd;

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_k7;
    logic       w_kerr;
    logic [5:0] w_6b;
    logic       w_flip6;
    rd_t        w_rd6;
    logic       w_alt;
    logic [3:0] w_4b_tab;
    logic       w_flip4;
    logic [3:0] w_4b;
    rd_t        w_rd_next;
    logic       w_accept;

    assign w_x = in_data[4:0];
    assign w_y = in_data[7:5];

`ifdef ENC8B10B_KCHAR_EN
    assign w_k28  = in_k && (w_x == 5'd28);
    assign w_k7   = in_k && (w_y == 3'd7) && C_K7_X[w_x];
    assign w_kerr = in_k && !(w_k28 || w_k7);
`else
    logic w_unused_k;
    assign w_unused_k = in_k;
    assign w_k28      = 1'b0;
    assign w_k7       = 1'b0;
    assign w_kerr     = 1'b0;
`endif

    assign w_6b    = w_k28 ? ((r_rd == RD_POS) ? C_K28_POS : C_K28_NEG)
                           : ((r_rd == RD_POS) ? C_6B_POS[w_x] : C_6B_NEG[w_x]);
    assign w_flip6 = disp6(w_6b);
    assign w_rd6   = rd_t'(r_rd ^ w_flip6);
    assign w_alt   = w_k28 || w_k7 ||
                     ((w_rd6 == RD_POS) ? C_ALT7_POS[w_x] : C_ALT7_NEG[w_x]);

    enc_3b4b u_3b4b (
        .y    (w_y),
        .rd6  (w_rd6),
        .alt  (w_alt),
        .fghj (w_4b_tab),
        .flip (w_flip4)
    );

    // K.28 neutral groups .1/.2/.5/.6 take the complement of the data code under rd6 = RD-
    assign w_4b      = (w_k28 && !w_flip4 && (w_y != 3'd3) && (w_rd6 == RD_NEG)) ? ~w_4b_tab : w_4b_tab;
    assign w_rd_next = rd_t'(w_rd6 ^ w_flip4);

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // Output register: load on accept, drop valid on consume, hold during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= 10'd0;
            r_err   <= 1'b0;
            r_rd    <= rd_t'(RD_INIT);
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_code  <= {w_6b, w_4b};
            r_err   <= w_kerr;
            r_rd    <= w_rd_next;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_rd    = r_rd;
    assign err_k     = r_err;

endmodule

// File: tb/tb_enc_8b10b.sv
// tb_enc_8b10b: scoreboard bench for enc_8b10b with directed, hand-computed code groups.
// Covers K-character vectors when ENC8B10B_KCHAR_EN is defined.
module tb_enc_8b10b;

    typedef struct packed {
        logic [9:0] code;
        logic       rd;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_k;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_code;
    logic       out_rd;
    logic       err_k;

    int   checks = 0;
    int   errors = 0;
    int   n_pushed = 0;
    int   n_seen = 0;
    exp_t exp_q[$];

    enc_8b10b #(.RD_INIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_rd    (out_rd),
        .err_k     (err_k)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops one expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_group actual=%0h required=none", out_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("code", {22'd0, out_code}, {22'd0, e.code});
                chk("rd", {31'd0, out_rd}, {31'd0, e.rd});
                chk("err_k", {31'd0, err_k}, {31'd0, e.err});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic k, input logic [9:0] c,
                        input logic r, input logic e);
        int n;
        in_data  = d;
        in_k     = k;
        in_valid = 1'b1;
        exp_q.push_back(exp_t'({c, r, e}));
        n_pushed++;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_k     = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_k      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_code", {22'd0, out_code}, 0);
        chk("rst_err", {31'd0, err_k}, 0);
        chk("rst_rd", {31'd0, out_rd}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);   // D.0.0 RD-
        send(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);   // D.0.0 again
        send(8'hB5, 1'b0, 10'h2AA, 1'b0, 1'b0);   // D.21.5 RD-
        send(8'hF1, 1'b0, 10'h237, 1'b1, 1'b0);   // D.17.7 alternate RD-
        send(8'hB5, 1'b0, 10'h2AA, 1'b1, 1'b0);   // D.21.5 RD+
        send(8'hEB, 1'b0, 10'h348, 1'b0, 1'b0);   // D.11.7 alternate RD+
        send(8'hEB, 1'b0, 10'h34E, 1'b1, 1'b0);   // D.11.7 primary RD-
        send(8'h63, 1'b0, 10'h313, 1'b1, 1'b0);   // D.3.3 RD+
        send(8'hE7, 1'b0, 10'h071, 1'b0, 1'b0);   // D.7.7 RD+
`ifdef ENC8B10B_KCHAR_EN
        send(8'hBC, 1'b1, 10'h0FA, 1'b1, 1'b0);   // K.28.5 RD-
        send(8'hBC, 1'b1, 10'h305, 1'b0, 1'b0);   // K.28.5 RD+
        send(8'h3C, 1'b1, 10'h0F9, 1'b1, 1'b0);   // K.28.1 RD-
        send(8'h3C, 1'b1, 10'h306, 1'b0, 1'b0);   // K.28.1 RD+
        send(8'h7C, 1'b1, 10'h0F3, 1'b1, 1'b0);   // K.28.3 RD-
        send(8'h7C, 1'b1, 10'h30C, 1'b0, 1'b0);   // K.28.3 RD+
        send(8'hF7, 1'b1, 10'h3A8, 1'b0, 1'b0);   // K.23.7 RD-
        send(8'h00, 1'b1, 10'h274, 1'b0, 1'b1);   // illegal K -> data, err_k
`else
        send(8'hBC, 1'b1, 10'h0EA, 1'b0, 1'b0);   // in_k ignored: D.28.5 RD-
`endif
        drain();

        // Backpressure: hold one group for three cycles while the next waits
        out_ready = 1'b0;
        send(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);
        in_data  = 8'hF1;
        in_k     = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_code", {22'd0, out_code}, 32'h274);
            chk("stall_rd", {31'd0, out_rd}, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'hF1, 1'b0, 10'h237, 1'b1, 1'b0);
        send(8'hB5, 1'b0, 10'h2AA, 1'b1, 1'b0);
        drain();

        // Reset mid-stream with a group held in the output register
        out_ready = 1'b0;
        send(8'h00, 1'b0, 10'h18B, 1'b1, 1'b0);   // D.0.0 RD+
        chk("held_valid", {31'd0, out_valid}, 1);
        chk("held_code", {22'd0, out_code}, 32'h18B);
        chk("held_rd", {31'd0, out_rd}, 1);
        exp_q.delete();
        n_pushed--;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_rd", {31'd0, out_rd}, 0);
        chk("mid_rst_code", {22'd0, out_code}, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);
        drain();

        chk("groups_seen", n_seen, n_pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
